// File: rtl/bla_pkg.sv
// Shared types and constants for the polygon edge sequencer and its vertex store.
// Vertex layout matches the packed command bus: x in the upper half, y in the lower half.
package bla_pkg;

  localparam int MAX_VERT = 8;
  localparam int COORD_W  = 8;
  localparam int NV_W     = $clog2(MAX_VERT + 1);
  localparam int IDX_W    = $clog2(MAX_VERT);
  localparam int VERT_W   = 2 * COORD_W;
  localparam int VERTS_W  = MAX_VERT * VERT_W;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CLEAR = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } seq_state_t;

  // Successor vertex index; wraps at the command's vertex count, not at MAX_VERT.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k,
                                                input logic [NV_W-1:0]  nvert);
    logic [IDX_W-1:0] r;
    if (NV_W'(k) + NV_W'(1) == nvert) r = '0;
    else                              r = k + IDX_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/bla_vertex_store.sv
// Holds the vertex array of the current polygon command and presents the endpoints
// of edge k (v[k] and its modulo-nvert successor) combinationally.
module bla_vertex_store
  import bla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [VERTS_W-1:0] verts_i,
  input  logic [NV_W-1:0]    nvert_i,
  input  logic [IDX_W-1:0]   k_i,
  output vertex_t            va_o,
  output vertex_t            vb_o
);

  vertex_t          verts_q [MAX_VERT];
  logic [IDX_W-1:0] kn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_VERT; i++) verts_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < MAX_VERT; i++) verts_q[i] <= verts_i[i*VERT_W +: VERT_W];
    end
  end

  assign kn   = next_idx(k_i, nvert_i);
  assign va_o = verts_q[k_i];
  assign vb_o = verts_q[kn];

endmodule

// File: rtl/bla_poly_sequencer.sv
// Polygon edge sequencer: accepts one polygon command, clears the line buffer once,
// then issues one line request per edge to the line engine and ends with done or error.
module bla_poly_sequencer
  import bla_pkg::*;
#(
  parameter int TIMEOUT = 8192
) (
  input  logic               clk,
  input  logic               rst,
  // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE; command fields are ignored when no transfer occurs.
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [NV_W-1:0]    cmd_nvert,
  input  logic               cmd_closed,
  input  logic [VERTS_W-1:0] cmd_verts,
  output logic               buf_clear,
  output logic               line_start,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1,
  input  logic               line_done,
  output logic               poly_done,
  output logic               poly_err,
  output logic               busy,
  output seq_state_t         dbg_state
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [NV_W-1:0]  e_q, e_d;
  logic [NV_W-1:0]  nvert_q, nvert_d;
  logic             closed_q, closed_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             load;
  logic             last_edge;
  logic             coord_en;
  vertex_t          va, vb;

  bla_vertex_store u_store (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .verts_i (cmd_verts),
    .nvert_i (nvert_q),
    .k_i     (k_q),
    .va_o    (va),
    .vb_o    (vb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      e_q      <= '0;
      nvert_q  <= '0;
      closed_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      e_q      <= e_d;
      nvert_q  <= nvert_d;
      closed_q <= closed_d;
      tmo_q    <= tmo_d;
    end
  end

  // e_q is at least 1 whenever the edge states are reachable, so the subtraction cannot wrap.
  assign last_edge = (NV_W'(k_q) == e_q - NV_W'(1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    e_d        = e_q;
    nvert_d    = nvert_q;
    closed_d   = closed_q;
    tmo_d      = tmo_q;
    load       = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    buf_clear  = 1'b0;
    line_start = 1'b0;
    poly_done  = 1'b0;
    poly_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          load     = 1'b1;
          nvert_d  = cmd_nvert;
          closed_d = cmd_closed;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (nvert_q < NV_W'(2) || nvert_q > NV_W'(MAX_VERT)) begin
          state_d = S_ERR;
        end else begin
          // Two vertices never form a closing edge; that would just retrace v1->v0.
          e_d     = (closed_q && nvert_q >= NV_W'(3)) ? nvert_q : nvert_q - NV_W'(1);
          k_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        buf_clear = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (va == vb) begin
          if (last_edge) state_d = S_FIN;
          else           k_d     = k_q + IDX_W'(1);
        end else begin
          line_start = 1'b1;
          tmo_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (line_done) begin
          if (last_edge) begin
            state_d = S_FIN;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = S_ISSUE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FIN: begin
        poly_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        poly_err = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Endpoints only leave zero while an edge is being issued or drawn; k is frozen in WAIT.
  assign coord_en  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign line_x0   = coord_en ? va.x : '0;
  assign line_y0   = coord_en ? va.y : '0;
  assign line_x1   = coord_en ? vb.x : '0;
  assign line_y1   = coord_en ? vb.y : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bla_poly_sequencer.sv
// Self-checking bench for bla_poly_sequencer: scoreboarded edge endpoints, a simple
// line-engine responder, and one task per scenario.
module tb_bla_poly_sequencer;
  import bla_pkg::*;

  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [NV_W-1:0]    cmd_nvert;
  logic               cmd_closed;
  logic [VERTS_W-1:0] cmd_verts;
  logic               buf_clear;
  logic               line_start;
  logic [COORD_W-1:0] line_x0, line_y0, line_x1, line_y1;
  logic               line_done;
  logic               poly_done;
  logic               poly_err;
  logic               busy;
  seq_state_t         dbg_state;

  int total  = 0;
  int passed = 0;
  int n_clear = 0, n_start = 0, n_done = 0, n_err = 0;
  logic [4*COORD_W-1:0] exp_q[$];

  int   done_delay = 5;
  int   resp_cnt   = 0;
  logic stray_req  = 1'b0;
  int   vx[MAX_VERT];
  int   vy[MAX_VERT];

  bla_poly_sequencer #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_nvert  (cmd_nvert),
    .cmd_closed (cmd_closed),
    .cmd_verts  (cmd_verts),
    .buf_clear  (buf_clear),
    .line_start (line_start),
    .line_x0    (line_x0),
    .line_y0    (line_y0),
    .line_x1    (line_x1),
    .line_y1    (line_y1),
    .line_done  (line_done),
    .poly_done  (poly_done),
    .poly_err   (poly_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // ---------------- line engine responder ----------------
  always @(negedge clk) begin
    line_done = 1'b0;
    if (rst) resp_cnt = 0;
    else if (stray_req) line_done = 1'b1;
    else if (line_start && done_delay > 0) resp_cnt = done_delay;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) line_done = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (buf_clear) n_clear++;
      if (poly_done) n_done++;
      if (poly_err)  n_err++;
      if (poly_done && poly_err) begin
        total++;
        $display("FAIL done_err_exclusive: both poly_done and poly_err high at %0t", $time);
      end
      if (line_start) begin
        n_start++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL edge: unexpected line_start %0d,%0d->%0d,%0d, none required",
                   line_x0, line_y0, line_x1, line_y1);
        end else begin
          logic [4*COORD_W-1:0] exp_e;
          exp_e = exp_q.pop_front();
          if ({line_x0, line_y0, line_x1, line_y1} !== exp_e)
            $display("FAIL edge: got %0d,%0d->%0d,%0d required %0d,%0d->%0d,%0d",
                     line_x0, line_y0, line_x1, line_y1,
                     exp_e[4*COORD_W-1 -: COORD_W], exp_e[3*COORD_W-1 -: COORD_W],
                     exp_e[2*COORD_W-1 -: COORD_W], exp_e[COORD_W-1 -: COORD_W]);
          else passed++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_verts(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
    for (int i = 0; i < MAX_VERT; i++) begin vx[i] = 0; vy[i] = 0; end
    vx[0] = x0; vy[0] = y0; vx[1] = x1; vy[1] = y1;
    vx[2] = x2; vy[2] = y2; vx[3] = x3; vy[3] = y3;
  endtask

  // Pushes the expected non-degenerate edges, then performs one accepted transfer.
  // Returns at the accept edge (+1); the next negedge is the CHECK cycle.
  task automatic send_cmd(input int nv, input bit closed);
    int e;
    int kn;
    int waited;
    if (nv >= 2 && nv <= MAX_VERT) begin
      e = (closed && nv >= 3) ? nv : nv - 1;
      for (int k = 0; k < e; k++) begin
        kn = (k + 1) % nv;
        if (vx[k] != vx[kn] || vy[k] != vy[kn])
          exp_q.push_back({COORD_W'(vx[k]), COORD_W'(vy[k]), COORD_W'(vx[kn]), COORD_W'(vy[kn])});
      end
    end
    for (int i = 0; i < MAX_VERT; i++) begin
      cmd_verts[i*VERT_W +: COORD_W]           = COORD_W'(vy[i]);
      cmd_verts[i*VERT_W + COORD_W +: COORD_W] = COORD_W'(vx[i]);
    end
    cmd_nvert  = NV_W'(nv);
    cmd_closed = closed;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL cmd_ready_wait: cmd_ready=%0b after 50 cycles, required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cycles, output bit got_done, output bit got_err);
    cycles = 0; got_done = 0; got_err = 0;
    while (cycles < budget && !got_done && !got_err) begin
      @(negedge clk);
      cycles++;
      got_done = poly_done;
      got_err  = poly_err;
    end
    if (!got_done && !got_err) begin
      total++;
      $display("FAIL end_wait: no poly_done/poly_err within %0d cycles", budget);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_nvert = '0; cmd_closed = 1'b0; cmd_verts = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, busy, buf_clear, line_start, poly_done, poly_err} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b required 100000",
               {cmd_ready, busy, buf_clear, line_start, poly_done, poly_err});
    else passed++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({line_x0, line_y0, line_x1, line_y1} !== '0 || dbg_state !== S_IDLE)
      $display("FAIL reset_idle: coords=%h state=%0d required 0 and IDLE",
               {line_x0, line_y0, line_x1, line_y1}, dbg_state);
    else passed++;
    total++;
    if (n_done + n_err !== 0) $display("FAIL reset_exit_pulse: got %0d pulses required 0", n_done + n_err);
    else passed++;
  endtask

  task automatic test_closed_square();
    int s_clr, s_st, clr_at, st_at, cyc;
    bit gd, ge;
    s_clr = n_clear; s_st = n_start; clr_at = 0; st_at = 0;
    done_delay = 5;
    set_verts(10, 10, 20, 10, 20, 20, 10, 20);
    send_cmd(4, 1'b1);
    for (int c = 1; c <= 10 && st_at == 0; c++) begin
      @(negedge clk);
      if (buf_clear)  clr_at = c;
      if (line_start) st_at  = c;
    end
    total++;
    if (clr_at !== 2 || st_at !== 3)
      $display("FAIL square_latency: clear at %0d start at %0d, required 2 and 3", clr_at, st_at);
    else passed++;
    wait_end(200, cyc, gd, ge);
    total++;
    if (gd !== 1'b1 || ge !== 1'b0) $display("FAIL square_done: done=%0b err=%0b required 1/0", gd, ge);
    else passed++;
    total++;
    if (n_clear - s_clr !== 1 || n_start - s_st !== 4)
      $display("FAIL square_counts: clears=%0d starts=%0d required 1 and 4", n_clear - s_clr, n_start - s_st);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL square_ready: ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    else passed++;
  endtask

  task automatic test_open_triangle();
    int s_st, cyc;
    bit gd, ge;
    done_delay = $urandom_range(1, 6);
    set_verts(30, 30, 60, 30, 45, 70, 0, 0);
    s_st = n_start;
    send_cmd(3, 1'b0);
    wait_end(200, cyc, gd, ge);
    total++;
    if (gd !== 1'b1 || n_start - s_st !== 2)
      $display("FAIL open_tri: done=%0b starts=%0d required 1 and 2", gd, n_start - s_st);
    else passed++;
    done_delay = $urandom_range(1, 6);
    s_st = n_start;
    send_cmd(2, 1'b1);
    wait_end(200, cyc, gd, ge);
    total++;
    if (gd !== 1'b1 || n_start - s_st !== 1)
      $display("FAIL two_vert_closed: done=%0b starts=%0d required 1 and 1", gd, n_start - s_st);
    else passed++;
  endtask

  task automatic test_bad_nvert(input int nv);
    int s_clr, s_st, s_err;
    s_clr = n_clear; s_st = n_start; s_err = n_err;
    set_verts(1, 2, 3, 4, 5, 6, 7, 8);
    send_cmd(nv, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (poly_err !== 1'b1 || poly_done !== 1'b0)
      $display("FAIL bad_nvert_%0d: err=%0b done=%0b required 1/0", nv, poly_err, poly_done);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || n_clear != s_clr || n_start != s_st || n_err - s_err !== 1)
      $display("FAIL bad_nvert_side_%0d: ready=%0b clears=%0d starts=%0d errs=%0d required 1,0,0,1",
               nv, cmd_ready, n_clear - s_clr, n_start - s_st, n_err - s_err);
    else passed++;
  endtask

  task automatic test_degenerate();
    int s_st, cyc;
    bit gd, ge;
    done_delay = 3;
    set_verts(5, 5, 5, 5, 9, 9, 0, 0);
    s_st = n_start;
    send_cmd(3, 1'b0);
    wait_end(200, cyc, gd, ge);
    total++;
    if (gd !== 1'b1 || ge !== 1'b0 || n_start - s_st !== 1)
      $display("FAIL degenerate: done=%0b err=%0b starts=%0d required 1,0,1", gd, ge, n_start - s_st);
    else passed++;
  endtask

  task automatic test_timeout();
    int s_st, st_at, cyc;
    bit gd, ge;
    done_delay = 0;
    st_at = 0;
    set_verts(1, 2, 3, 4, 0, 0, 0, 0);
    s_st = n_start;
    send_cmd(2, 1'b0);
    for (int c = 1; c <= 10 && st_at == 0; c++) begin
      @(negedge clk);
      if (line_start) st_at = c;
    end
    wait_end(TMO + 10, cyc, gd, ge);
    total++;
    if (ge !== 1'b1 || gd !== 1'b0 || cyc !== TMO + 1)
      $display("FAIL timeout: err=%0b done=%0b after %0d cycles, required 1,0,%0d", ge, gd, cyc, TMO + 1);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || n_start - s_st !== 1)
      $display("FAIL timeout_after: ready=%0b starts=%0d required 1 and 1", cmd_ready, n_start - s_st);
    else passed++;
    done_delay = 5;
  endtask

  task automatic test_reset_mid_wait();
    int s_st, guard, cyc;
    bit gd, ge, saw_busy;
    done_delay = 5;
    set_verts(10, 10, 20, 10, 20, 20, 10, 20);
    s_st = n_start;
    send_cmd(4, 1'b1);
    guard = 0;
    while (n_start - s_st < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, busy, buf_clear, line_start, poly_done, poly_err} !== 6'b100000 ||
        {line_x0, line_y0, line_x1, line_y1} !== '0 || dbg_state !== S_IDLE)
      $display("FAIL rst_mid_wait: ctrl=%b coords=%h state=%0d required 100000, 0, IDLE",
               {cmd_ready, busy, buf_clear, line_start, poly_done, poly_err},
               {line_x0, line_y0, line_x1, line_y1}, dbg_state);
    else passed++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    s_st = n_start;
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    saw_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    total++;
    if (saw_busy !== 1'b0 || n_start != s_st)
      $display("FAIL stray_done: busy_seen=%0b starts=%0d required 0 and 0", saw_busy, n_start - s_st);
    else passed++;
    send_cmd(4, 1'b1);
    wait_end(200, cyc, gd, ge);
    total++;
    if (gd !== 1'b1 || n_start - s_st !== 4)
      $display("FAIL after_rst_cmd: done=%0b starts=%0d required 1 and 4", gd, n_start - s_st);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_closed_square();
    test_open_triangle();
    test_bad_nvert(1);
    test_bad_nvert(9);
    test_degenerate();
    test_timeout();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d edges never issued, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
